// File: rtl/div_unit_pkg.sv
// Shared definitions for the iterative restoring divider: FSM encodings,
// default sizing and the div_signal bit positions driven by the decoder.
package div_unit_pkg;

    localparam int DIV_WIDTH  = 32;
    localparam int DIV_CNT_W  = 5;
    localparam int DIV_START  = 1;
    localparam int DIV_SIGNED = 0;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_RUN  = 2'd1,
        DIV_FIN  = 2'd2
    } div_state_e;

endpackage

// File: rtl/div_unit_step.sv
// One restoring-division iteration: shift {rem,quo} left by one, then
// subtract the divisor when it fits and record the quotient bit.
module div_unit_step
    import div_unit_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic [WIDTH-1:0] quo_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic [WIDTH-1:0] quo_out
);

    logic [WIDTH:0] rem_shift_s;
    logic [WIDTH:0] diff_s;

    assign rem_shift_s = {rem_in, quo_in[WIDTH-1]};
    // WIDTH+1 bits are enough: the borrow lands in bit WIDTH when the divisor does not fit
    assign diff_s      = rem_shift_s - {1'b0, divisor};

    // Restore or keep the difference depending on the borrow
    always_comb begin
        rem_out = rem_shift_s[WIDTH-1:0];
        quo_out = {quo_in[WIDTH-2:0], 1'b0};
        if (!diff_s[WIDTH]) begin
            rem_out = diff_s[WIDTH-1:0];
            quo_out = {quo_in[WIDTH-2:0], 1'b1};
        end else begin
            rem_out = rem_shift_s[WIDTH-1:0];
            quo_out = {quo_in[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/div_unit.sv
// EX-stage radix-2 restoring divider: 32 iterations on magnitudes, then a
// sign-fix cycle that registers LO (quotient) and HI (remainder).
module div_unit
    import div_unit_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = DIV_CNT_W
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [1:0]       div_signal,
    input  logic [WIDTH-1:0] div_op_a,
    input  logic [WIDTH-1:0] div_op_b,
    input  logic             flush,
    output logic             div_busy,
    output logic             div_done,
    output logic [WIDTH-1:0] div_quotient,
    output logic [WIDTH-1:0] div_remainder
);

    div_state_e       state_r, state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [WIDTH-1:0] rem_r, quo_r, divisor_r;
    logic [WIDTH-1:0] step_rem_s, step_quo_s;
    logic [WIDTH-1:0] abs_a_s, abs_b_s, fix_quo_s, fix_rem_s;
    logic             sign_q_r, sign_r_r, zero_r;
    logic             start_s, a_neg_s, b_neg_s;
    logic             busy_r, done_r;
    logic [WIDTH-1:0] quotient_r, remainder_r;

    assign start_s = div_signal[DIV_START] & ~flush;
    assign a_neg_s = div_signal[DIV_SIGNED] & div_op_a[WIDTH-1];
    assign b_neg_s = div_signal[DIV_SIGNED] & div_op_b[WIDTH-1];
    // abs(most-negative) wraps to itself, which is the correct unsigned magnitude
    assign abs_a_s = a_neg_s ? ({WIDTH{1'b0}} - div_op_a) : div_op_a;
    assign abs_b_s = b_neg_s ? ({WIDTH{1'b0}} - div_op_b) : div_op_b;

    div_unit_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (rem_r),
        .quo_in  (quo_r),
        .divisor (divisor_r),
        .rem_out (step_rem_s),
        .quo_out (step_quo_s)
    );

    // Sign fix; a zero divisor forces all-ones quotient and returns the raw dividend
    always_comb begin
        fix_quo_s = quo_r;
        fix_rem_s = rem_r;
        if (zero_r) begin
            fix_quo_s = {WIDTH{1'b1}};
        end else if (sign_q_r) begin
            fix_quo_s = {WIDTH{1'b0}} - quo_r;
        end else begin
            fix_quo_s = quo_r;
        end
        if (sign_r_r) begin
            fix_rem_s = {WIDTH{1'b0}} - rem_r;
        end else begin
            fix_rem_s = rem_r;
        end
    end

    // Next-state logic; flush returns to IDLE from any state
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            DIV_IDLE: begin
                if (start_s) state_nxt_s = DIV_RUN;
                else         state_nxt_s = DIV_IDLE;
            end
            DIV_RUN: begin
                if (flush)                              state_nxt_s = DIV_IDLE;
                else if (cnt_r == CNT_W'(WIDTH - 1))    state_nxt_s = DIV_FIN;
                else                                    state_nxt_s = DIV_RUN;
            end
            DIV_FIN:  state_nxt_s = DIV_IDLE;
            default:  state_nxt_s = DIV_IDLE;
        endcase
    end

    // State register and busy flag
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r <= DIV_IDLE;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= (state_nxt_s != DIV_IDLE);
        end
    end

    // Operand latch, iteration datapath and result registers
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt_r       <= {CNT_W{1'b0}};
            rem_r       <= {WIDTH{1'b0}};
            quo_r       <= {WIDTH{1'b0}};
            divisor_r   <= {WIDTH{1'b0}};
            sign_q_r    <= 1'b0;
            sign_r_r    <= 1'b0;
            zero_r      <= 1'b0;
            done_r      <= 1'b0;
            quotient_r  <= {WIDTH{1'b0}};
            remainder_r <= {WIDTH{1'b0}};
        end else begin
            done_r <= 1'b0;
            case (state_r)
                DIV_IDLE: begin
                    if (start_s) begin
                        cnt_r     <= {CNT_W{1'b0}};
                        rem_r     <= {WIDTH{1'b0}};
                        quo_r     <= abs_a_s;
                        divisor_r <= abs_b_s;
                        sign_q_r  <= a_neg_s ^ b_neg_s;
                        sign_r_r  <= a_neg_s;
                        zero_r    <= (div_op_b == {WIDTH{1'b0}});
                    end
                end
                DIV_RUN: begin
                    if (!flush) begin
                        rem_r <= step_rem_s;
                        quo_r <= step_quo_s;
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                DIV_FIN: begin
                    if (!flush) begin
                        quotient_r  <= fix_quo_s;
                        remainder_r <= fix_rem_s;
                        done_r      <= 1'b1;
                    end
                end
                default: begin
                    done_r <= 1'b0;
                end
            endcase
        end
    end

    assign div_busy      = busy_r;
    assign div_done      = done_r;
    assign div_quotient  = quotient_r;
    assign div_remainder = remainder_r;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed vector table, flush/reset/back-to-back
// sequences, and randomized operations against an arithmetic reference model.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        resetn;
    logic [1:0]  div_signal;
    logic [31:0] div_op_a, div_op_b;
    logic        flush;
    logic        div_busy, div_done;
    logic [31:0] div_quotient, div_remainder;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    div_unit dut (
        .clk           (clk),
        .resetn        (resetn),
        .div_signal    (div_signal),
        .div_op_a      (div_op_a),
        .div_op_b      (div_op_b),
        .flush         (flush),
        .div_busy      (div_busy),
        .div_done      (div_done),
        .div_quotient  (div_quotient),
        .div_remainder (div_remainder)
    );

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic        sgn;
        logic [31:0] q;
        logic [31:0] r;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    endtask

    // Reference: plain integer arithmetic (truncating division, remainder takes dividend sign)
    function automatic void ref_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                                    output logic [31:0] q, output logic [31:0] r);
        longint sa, sb;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (!s) begin
            q = a / b;
            r = a % b;
        end else begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = 32'(sa / sb);
            r  = 32'(sa % sb);
        end
    endfunction

    // Caller sits at a negedge: present the start for one cycle, then confirm busy rose
    task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic s);
        div_op_a   = a;
        div_op_b   = b;
        div_signal = {1'b1, s};
        @(negedge clk);
        div_signal = 2'b00;
        check("busy_after_accept", {31'd0, div_busy}, 32'd1);
    endtask

    // Count cycles from 'from' until done, bounded
    task automatic wait_done(input int from, output int lat);
        lat = from;
        while (!div_done && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_check(input string name, input logic [31:0] a, input logic [31:0] b,
                             input logic s, input logic [31:0] eq, input logic [31:0] er);
        int lat;
        @(negedge clk);
        launch(a, b, s);
        wait_done(1, lat);
        check({name, "_latency"}, 32'(lat), 32'd34);
        check({name, "_q"}, div_quotient, eq);
        check({name, "_r"}, div_remainder, er);
    endtask

    initial begin
        int lat, dones;
        logic [31:0] eq, er, ra, rb;
        logic rs;

        vecs[0] = '{"divu_100_7",    32'd100,        32'd7,          1'b0, 32'd14,         32'd2};
        vecs[1] = '{"div_m7_2",      32'hFFFF_FFF9,  32'd2,          1'b1, 32'hFFFF_FFFD,  32'hFFFF_FFFF};
        vecs[2] = '{"div_m7_m2",     32'hFFFF_FFF9,  32'hFFFF_FFFE,  1'b1, 32'd3,          32'hFFFF_FFFF};
        vecs[3] = '{"div_ovf",       32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32'h8000_0000,  32'd0};
        vecs[4] = '{"divu_max_1",    32'hFFFF_FFFF,  32'd1,          1'b0, 32'hFFFF_FFFF,  32'd0};
        vecs[5] = '{"divu_by0",      32'h0000_1234,  32'd0,          1'b0, 32'hFFFF_FFFF,  32'h0000_1234};
        vecs[6] = '{"div_by0",       32'h0000_1234,  32'd0,          1'b1, 32'hFFFF_FFFF,  32'h0000_1234};
        vecs[7] = '{"div_neg_by0",   32'hFFFF_FFF9,  32'd0,          1'b1, 32'hFFFF_FFFF,  32'hFFFF_FFF9};
        vecs[8] = '{"divu_big",      32'hFFFF_FFFE,  32'hFFFF_FFFF,  1'b0, 32'd0,          32'hFFFF_FFFE};

        resetn = 1'b0; div_signal = 2'b00; div_op_a = 32'd0; div_op_b = 32'd0; flush = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_busy", {31'd0, div_busy}, 32'd0);
        check("reset_done", {31'd0, div_done}, 32'd0);
        check("reset_q", div_quotient, 32'd0);
        check("reset_r", div_remainder, 32'd0);
        resetn = 1'b1;

        for (int i = 0; i < 9; i++)
            run_check(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].sgn, vecs[i].q, vecs[i].r);

        // Flush 10 cycles after accept; prior result (100/7) must survive
        run_check("pre_flush", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2);
        @(negedge clk);
        launch(32'h0000_1000, 32'd3, 1'b0);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy", {31'd0, div_busy}, 32'd0);
        check("flush_done", {31'd0, div_done}, 32'd0);
        check("flush_keep_q", div_quotient, 32'd14);
        check("flush_keep_r", div_remainder, 32'd2);
        launch(32'd1000, 32'd9, 1'b0);
        wait_done(1, lat);
        check("after_flush_latency", 32'(lat), 32'd34);
        check("after_flush_q", div_quotient, 32'd111);
        check("after_flush_r", div_remainder, 32'd1);

        // Flush in the FIN cycle suppresses done and the output update
        @(negedge clk);
        launch(32'd50, 32'd5, 1'b0);
        repeat (32) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("fin_flush_done", {31'd0, div_done}, 32'd0);
        check("fin_flush_busy", {31'd0, div_busy}, 32'd0);
        check("fin_flush_q", div_quotient, 32'd111);

        // Start together with flush in IDLE is dropped
        div_op_a = 32'd9; div_op_b = 32'd3; div_signal = 2'b10; flush = 1'b1;
        @(negedge clk);
        div_signal = 2'b00; flush = 1'b0;
        check("flush_start_dropped", {31'd0, div_busy}, 32'd0);

        // Back-to-back: second start in the done cycle, an ignored start while busy
        @(negedge clk);
        launch(32'd77, 32'd10, 1'b0);
        wait_done(1, lat);
        check("b2b_first_q", div_quotient, 32'd7);
        launch(32'hFFFF_FF9C, 32'd7, 1'b1);
        repeat (4) @(negedge clk);
        div_op_a = 32'd5; div_op_b = 32'd1; div_signal = 2'b10;
        @(negedge clk);
        div_signal = 2'b00;
        wait_done(6, lat);
        check("b2b_second_latency", 32'(lat), 32'd34);
        check("b2b_second_q", div_quotient, 32'hFFFF_FFF2);
        check("b2b_second_r", div_remainder, 32'hFFFF_FFFE);
        dones = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (div_done) dones++;
        end
        check("b2b_no_extra_done", 32'(dones), 32'd0);

        // Reset mid-operation clears everything
        @(negedge clk);
        launch(32'd123, 32'd4, 1'b0);
        repeat (9) @(negedge clk);
        resetn = 1'b0; flush = 1'b1; div_signal = 2'b10;
        @(negedge clk);
        check("midreset_busy", {31'd0, div_busy}, 32'd0);
        check("midreset_done", {31'd0, div_done}, 32'd0);
        check("midreset_q", div_quotient, 32'd0);
        check("midreset_r", div_remainder, 32'd0);
        resetn = 1'b1; flush = 1'b0; div_signal = 2'b00;

        // Randomized operations against the reference model
        for (int i = 0; i < 30; i++) begin
            ra = $urandom;
            rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
            if ($urandom_range(0, 1) == 1) rb = rb >> $urandom_range(0, 31);
            rs = 1'($urandom_range(0, 1));
            ref_div(ra, rb, rs, eq, er);
            run_check("random", ra, rb, rs, eq, er);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
